// File: rtl/multi_periodic_trigger_pkg.sv
// Shared constants and FSM encoding for the multi-channel periodic trigger.
package multi_periodic_trigger_pkg;

    localparam int unsigned DEF_NUM_CH = 2;
    localparam int unsigned DEF_INT_W  = 16;
    localparam int unsigned DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multi_periodic_trigger_if.sv
// Control/status bundle between a run controller and multi_periodic_trigger.
interface multi_periodic_trigger_if
    import multi_periodic_trigger_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned INT_W  = DEF_INT_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) ();

    logic                              start;
    logic                              abort;
    logic [NUM_CH-1:0]                 ch_en;
    logic [NUM_CH-1:0][INT_W-1:0]      interval;
    logic [INT_W-1:0]                  window;
    logic [NUM_CH-1:0]                 trig;
    logic [NUM_CH-1:0][CNT_W-1:0]      trig_count;
    logic                              busy;
    logic                              done;
    logic                              aborted;

    modport master (
        output start, abort, ch_en, interval, window,
        input  trig, trig_count, busy, done, aborted
    );

    modport slave (
        input  start, abort, ch_en, interval, window,
        output trig, trig_count, busy, done, aborted
    );

endinterface

// File: rtl/multi_periodic_trigger_trig_channel.sv
// One trigger channel: latched config, phase counter, pulse and saturating count.
module trig_channel
    import multi_periodic_trigger_pkg::*;
#(
    parameter int unsigned INT_W = DEF_INT_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [INT_W-1:0] interval,
    input  logic             active,
    output logic             trig,
    output logic [CNT_W-1:0] count
);

    logic             en_q;
    logic [INT_W-1:0] ivl_q;
    logic [INT_W-1:0] phase;
    logic             phase_wrap;

    assign phase_wrap = (phase == ivl_q - INT_W'(1));

    // A zero interval never fires, so the phase counter value is irrelevant then.
    assign trig = active && en_q && (ivl_q != '0) && (phase == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q  <= 1'b0;
            ivl_q <= '0;
            phase <= '0;
            count <= '0;
        end else if (load) begin
            en_q  <= en;
            ivl_q <= interval;
            phase <= '0;
            count <= '0;
        end else if (active) begin
            phase <= phase_wrap ? '0 : phase + INT_W'(1);
            if (trig && (count != '1)) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/multi_periodic_trigger.sv
// Run controller: window counter and IDLE/RUN/DONE FSM driving NUM_CH trigger channels.
module multi_periodic_trigger
    import multi_periodic_trigger_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned INT_W  = DEF_INT_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multi_periodic_trigger_if.slave  bus
);

    state_t                      state;
    state_t                      state_nxt;
    logic [INT_W-1:0]            win_q;
    logic [INT_W-1:0]            k;
    logic                        aborted_q;
    logic                        accept;
    logic                        last;
    logic                        active;
    logic [NUM_CH-1:0]           trig_v;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_v;

    assign accept = (state == ST_IDLE) && bus.start;
    // A zero window still spends one RUN cycle, but never enables the channels.
    assign last   = (win_q == '0) || (k == win_q - INT_W'(1));
    assign active = (state == ST_RUN) && !bus.abort && (win_q != '0);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.start) state_nxt = ST_RUN;
            ST_RUN:  if (last || bus.abort) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q     <= '0;
            k         <= '0;
            aborted_q <= 1'b0;
        end else if (accept) begin
            win_q     <= bus.window;
            k         <= '0;
            aborted_q <= 1'b0;
        end else if (state == ST_RUN) begin
            k <= k + INT_W'(1);
            if (bus.abort) begin
                aborted_q <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        trig_channel #(
            .INT_W (INT_W),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (accept),
            .en       (bus.ch_en[i]),
            .interval (bus.interval[i]),
            .active   (active),
            .trig     (trig_v[i]),
            .count    (cnt_v[i])
        );
    end

    assign bus.trig       = trig_v;
    assign bus.trig_count = cnt_v;
    assign bus.busy       = (state == ST_RUN);
    assign bus.done       = (state == ST_DONE);
    assign bus.aborted    = aborted_q;

endmodule

// File: tb/tb_multi_periodic_trigger.sv
// Directed bench for multi_periodic_trigger: full run, abort, disabled/zero window, saturation, reset.
module tb_multi_periodic_trigger;
    import multi_periodic_trigger_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    multi_periodic_trigger_if #(.NUM_CH(2), .INT_W(16), .CNT_W(16)) bus_a ();
    multi_periodic_trigger_if #(.NUM_CH(2), .INT_W(16), .CNT_W(3))  bus_s ();

    multi_periodic_trigger #(.NUM_CH(2), .INT_W(16), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    multi_periodic_trigger #(.NUM_CH(2), .INT_W(16), .CNT_W(3)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.ch_en = '0;
        bus_a.interval = '0; bus_a.window = '0;
        bus_s.start = 1'b0; bus_s.abort = 1'b0; bus_s.ch_en = '0;
        bus_s.interval = '0; bus_s.window = '0;
        #1 rst_n = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_busy", 32'(bus_a.busy), 0);
        chk("rst_done", 32'(bus_a.done), 0);
        chk("rst_trig", 32'(bus_a.trig), 0);
        chk("rst_cnt0", 32'(bus_a.trig_count[0]), 0);
        chk("rst_aborted", 32'(bus_a.aborted), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // full run {20,40}/200, inputs scrambled and start pulsed mid-run
        bus_a.ch_en = 2'b11; bus_a.interval[0] = 16'd20; bus_a.interval[1] = 16'd40;
        bus_a.window = 16'd200; bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            chk($sformatf("s1_busy k=%0d", k), 32'(bus_a.busy), 1);
            chk($sformatf("s1_trig0 k=%0d", k), 32'(bus_a.trig[0]), 32'(k % 20 == 0));
            chk($sformatf("s1_trig1 k=%0d", k), 32'(bus_a.trig[1]), 32'(k % 40 == 0));
            chk($sformatf("s1_done k=%0d", k), 32'(bus_a.done), 0);
            if (k == 21) chk("s1_cnt0_k21", 32'(bus_a.trig_count[0]), 2);
            if (k == 10) begin
                bus_a.ch_en = 2'b00; bus_a.interval[0] = 16'd3; bus_a.interval[1] = 16'd3;
                bus_a.window = 16'd5; bus_a.start = 1'b1;
            end
            if (k == 11) bus_a.start = 1'b0;
            @(negedge clk);
        end
        chk("s1_done", 32'(bus_a.done), 1);
        chk("s1_busy_end", 32'(bus_a.busy), 0);
        chk("s1_trig_end", 32'(bus_a.trig), 0);
        chk("s1_cnt0", 32'(bus_a.trig_count[0]), 10);
        chk("s1_cnt1", 32'(bus_a.trig_count[1]), 5);
        chk("s1_aborted", 32'(bus_a.aborted), 0);
        @(negedge clk);
        chk("s1_done_once", 32'(bus_a.done), 0);
        chk("s1_cnt0_held", 32'(bus_a.trig_count[0]), 10);
        chk("s1_cnt1_held", 32'(bus_a.trig_count[1]), 5);

        // abort at k=50
        bus_a.ch_en = 2'b11; bus_a.interval[0] = 16'd20; bus_a.interval[1] = 16'd40;
        bus_a.window = 16'd200; bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        for (int k = 0; k < 50; k++) @(negedge clk);
        bus_a.abort = 1'b1;
        #1;
        chk("s2_trig_abort", 32'(bus_a.trig), 0);
        chk("s2_busy_abort", 32'(bus_a.busy), 1);
        @(negedge clk);
        bus_a.abort = 1'b0;
        chk("s2_done", 32'(bus_a.done), 1);
        chk("s2_aborted", 32'(bus_a.aborted), 1);
        chk("s2_cnt0", 32'(bus_a.trig_count[0]), 3);
        chk("s2_cnt1", 32'(bus_a.trig_count[1]), 2);
        @(negedge clk);
        chk("s2_done_once", 32'(bus_a.done), 0);
        chk("s2_aborted_held", 32'(bus_a.aborted), 1);

        // reset while idle clears aborted and counts
        rst_n = 1'b0;
        #1;
        chk("s2r_aborted", 32'(bus_a.aborted), 0);
        chk("s2r_cnt0", 32'(bus_a.trig_count[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ch0 disabled, ch1 interval 0, window 0, start with abort in IDLE
        bus_a.ch_en = 2'b10; bus_a.interval[0] = 16'd5; bus_a.interval[1] = 16'd0;
        bus_a.window = 16'd0; bus_a.start = 1'b1; bus_a.abort = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0; bus_a.abort = 1'b0;
        chk("s3_busy", 32'(bus_a.busy), 1);
        chk("s3_trig", 32'(bus_a.trig), 0);
        chk("s3_aborted_run", 32'(bus_a.aborted), 0);
        @(negedge clk);
        chk("s3_done", 32'(bus_a.done), 1);
        chk("s3_busy_end", 32'(bus_a.busy), 0);
        chk("s3_cnt0", 32'(bus_a.trig_count[0]), 0);
        chk("s3_cnt1", 32'(bus_a.trig_count[1]), 0);
        chk("s3_aborted", 32'(bus_a.aborted), 0);
        @(negedge clk);
        chk("s3_done_once", 32'(bus_a.done), 0);

        // CNT_W=3 saturation, start pulsed during RUN
        bus_s.ch_en = 2'b11; bus_s.interval[0] = 16'd1; bus_s.interval[1] = 16'd4;
        bus_s.window = 16'd20; bus_s.start = 1'b1;
        @(negedge clk);
        bus_s.start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("s4_busy k=%0d", k), 32'(bus_s.busy), 1);
            chk($sformatf("s4_trig0 k=%0d", k), 32'(bus_s.trig[0]), 1);
            chk($sformatf("s4_trig1 k=%0d", k), 32'(bus_s.trig[1]), 32'(k % 4 == 0));
            chk($sformatf("s4_cnt0 k=%0d", k), 32'(bus_s.trig_count[0]), (k > 7) ? 7 : k);
            chk($sformatf("s4_cnt1 k=%0d", k), 32'(bus_s.trig_count[1]), (k + 3) / 4);
            if (k == 5) bus_s.start = 1'b1;
            if (k == 6) bus_s.start = 1'b0;
            @(negedge clk);
        end
        chk("s4_done", 32'(bus_s.done), 1);
        chk("s4_cnt0", 32'(bus_s.trig_count[0]), 7);
        chk("s4_cnt1", 32'(bus_s.trig_count[1]), 5);
        @(negedge clk);
        chk("s4_done_once", 32'(bus_s.done), 0);
        chk("s4_busy_idle", 32'(bus_s.busy), 0);

        // reset at k=100, then restart on the release edge
        bus_a.ch_en = 2'b11; bus_a.interval[0] = 16'd20; bus_a.interval[1] = 16'd40;
        bus_a.window = 16'd200; bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        for (int k = 0; k < 100; k++) @(negedge clk);
        chk("s5_pre_cnt0", 32'(bus_a.trig_count[0]), 5);
        chk("s5_pre_cnt1", 32'(bus_a.trig_count[1]), 3);
        chk("s5_pre_trig0", 32'(bus_a.trig[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("s5_rst_trig", 32'(bus_a.trig), 0);
        chk("s5_rst_cnt0", 32'(bus_a.trig_count[0]), 0);
        chk("s5_rst_cnt1", 32'(bus_a.trig_count[1]), 0);
        chk("s5_rst_busy", 32'(bus_a.busy), 0);
        chk("s5_rst_done", 32'(bus_a.done), 0);
        chk("s5_rst_aborted", 32'(bus_a.aborted), 0);
        chk("s5_rst_s_cnt0", 32'(bus_s.trig_count[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            chk($sformatf("s5_trig0 k=%0d", k), 32'(bus_a.trig[0]), 32'(k % 20 == 0));
            chk($sformatf("s5_trig1 k=%0d", k), 32'(bus_a.trig[1]), 32'(k % 40 == 0));
            @(negedge clk);
        end
        chk("s5_done", 32'(bus_a.done), 1);
        chk("s5_cnt0", 32'(bus_a.trig_count[0]), 10);
        chk("s5_cnt1", 32'(bus_a.trig_count[1]), 5);
        chk("s5_aborted", 32'(bus_a.aborted), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_periodic_trigger.md
MULTI_PERIODIC_TRIGGER -- requirements
Module: multi_periodic_trigger

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent trigger channels.
REQ-002 SHALL have parameter INT_W, default 16: width of interval and window values, in cycles.
REQ-003 SHALL have parameter CNT_W, default 16: width of each per-channel trigger counter.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit: begins a run when sampled high in IDLE.
REQ-007 SHALL have port abort, input, 1 bit: ends a run early when sampled high in RUN.
REQ-008 SHALL have port ch_en, input, NUM_CH bits: per-channel enable, sampled at start.
REQ-009 SHALL have port interval, input, NUM_CH x INT_W: per-channel trigger period in cycles, sampled at start.
REQ-010 SHALL have port window, input, INT_W: run length in cycles, sampled at start.
REQ-011 SHALL have port trig, output, NUM_CH bits: one-cycle trigger pulse per channel.
REQ-012 SHALL have port trig_count, output, NUM_CH x CNT_W: number of triggers issued per channel in the current or last run.
REQ-013 SHALL have port busy, output, 1 bit: high in RUN.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse marking run end.
REQ-015 SHALL have port aborted, output, 1 bit: high if the last run ended by abort; held until next start.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on window expiry or abort; DONE->IDLE unconditionally after one cycle.
REQ-017 SHALL, on accepting start, latch ch_en, interval and window, clear all trig_count and aborted, and enter RUN the next cycle.
REQ-018 SHALL number RUN cycles k = 0..window-1, with k=0 the first cycle after start is accepted; RUN lasts exactly window cycles.
REQ-019 SHALL assert trig[i] in RUN cycle k iff ch_en[i]=1, interval[i]!=0, and k mod interval[i] == 0 (first trigger at k=0).
REQ-020 SHALL increment trig_count[i] by one in the cycle after each trig[i] pulse, saturating at 2^CNT_W-1 without wrap.
REQ-021 SHALL treat interval[i]=0 as a disabled channel: no triggers, count stays 0.
REQ-022 SHALL, with window=0, go RUN->DONE after one RUN cycle with no triggers and all counts 0.
REQ-023 SHALL assert done for exactly the one DONE cycle; trig_count SHALL be final in that cycle and held unchanged through IDLE until the next accepted start.
REQ-024 SHALL, on abort in RUN cycle k, issue no trigger in that cycle, go to DONE next cycle, and set aborted; counts reflect triggers issued in cycles 0..k-1.
REQ-025 SHALL ignore start while in RUN or DONE; start and abort together in IDLE SHALL start a run (abort has no effect outside RUN).
REQ-026 SHALL keep trig all-zero outside RUN; changes to ch_en/interval/window during RUN SHALL have no effect.

Reset
REQ-027 SHALL, on rst_n low, immediately force state IDLE, trig=0, trig_count=0, busy=0, done=0, aborted=0, and clear all phase and window counters, including mid-run.
REQ-028 SHALL resume operation on the first rising clk edge after rst_n deasserts; start seen on that edge SHALL be accepted.

Structure
REQ-029 SHALL place the FSM state enum and default parameter constants in package multi_periodic_trigger_pkg.
REQ-030 SHALL implement per-channel phase counter, trigger pulse and saturating count in sub-module trig_channel, instantiated NUM_CH times by generate loop.
REQ-031 SHALL keep the window counter, FSM, busy, done and aborted in the top module.

Verification
REQ-032 SHALL cover: NUM_CH=2, intervals {20,40}, window=200, both enabled -> trig[0] at k=0,20..180, trig[1] at k=0,40..160; done once; counts {10,5}; aborted=0.
REQ-033 SHALL cover: intervals {20,40}, window=200, abort at k=50 -> counts {3,2}; done at cycle after abort; aborted=1.
REQ-034 SHALL cover: ch_en=2'b10 with interval[1]=0, and window=0 -> counts {0,0}; no trig pulses; done pulses once.
REQ-035 SHALL cover: CNT_W=3, interval 1, window 20 -> count saturates at 7; start pulsed during RUN ignored.
REQ-036 SHALL cover: rst_n low at k=100 of a {20,40}/200 run -> all outputs 0 immediately; new start after release gives counts {10,5}.
